// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the dual-issue fetch sequencer: FSM states, pair bundle, NOP.
// Optional perf counters are enabled with FETCH_PERF_EN (see fetch_ctrl.sv).
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr1;
    logic [INSTR_W-1:0] instr2;
    logic               valid2;
  } pair_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid plus output register for fetched pairs, valid/ready handshake,
// with a synchronous flush that drops everything held.
module fetch_skid_buf
  import fetch_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  flush_i,
  input  logic  in_valid_i,
  input  pair_t in_pair_i,
  input  logic  out_ready_i,
  output logic  out_valid_o,
  output pair_t out_pair_o,
  output logic  skid_vld_o
);

  logic  out_vld_q, out_vld_d;
  logic  skid_vld_q, skid_vld_d;
  pair_t out_q, out_d;
  pair_t skid_q, skid_d;
  logic  free;

  assign free = ~out_vld_q | out_ready_i;

  always_comb begin
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    out_d      = out_q;
    skid_d     = skid_q;
    if (flush_i) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (free) begin
      // older skid entry goes first to keep FIFO order
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = in_valid_i;
        skid_d     = in_pair_i;
      end else begin
        out_vld_d = in_valid_i;
        if (in_valid_i) out_d = in_pair_i;
      end
    end else if (in_valid_i) begin
      skid_vld_d = 1'b1;
      skid_d     = in_pair_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign out_valid_o = out_vld_q;
  assign out_pair_o  = out_q;
  assign skid_vld_o  = skid_vld_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer for a 2-word synchronous ROM with redirect and skid buffer.
// Define FETCH_PERF_EN to add the perf_pairs/perf_stall/perf_redir counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redir_valid,
  input  logic [31:0]       redir_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr1,
  input  logic [31:0]       rom_instr2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr1,
  output logic [31:0]       out_instr2,
  output logic              out_valid2
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_pairs,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_redir
`endif
);

  localparam logic [ADDR_W-1:0] LAST_W = '1;
  localparam logic [ADDR_W-1:0] RST_W  = RESET_PC[ADDR_W+1:2];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ifl_w_q, ifl_w_d;
  logic              ifl_vld_q, ifl_vld_d;
  logic              ifl_v2_q, ifl_v2_d;
  state_e            state_q, state_d;

  logic [ADDR_W-1:0] iss_w, nxt_w;
  logic              issue, ret_vld, skid_vld, skid_load;
  pair_t             ret_pair, out_pair;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^{redir_pc[31:ADDR_W+2], redir_pc[1:0]};

  assign iss_w    = redir_valid ? redir_pc[ADDR_W+1:2] : pc_q;
  assign rom_addr = iss_w;
  assign nxt_w    = (iss_w == LAST_W) ? '0 : iss_w + ADDR_W'(2);

  // a redirect flushes the skid, so only fetch_en gates it
  assign issue = fetch_en &
    (redir_valid | (~skid_vld & ~(out_valid & ~out_ready & ifl_vld_q)));

  always_comb begin
    pc_d      = pc_q;
    ifl_vld_d = issue;
    ifl_w_d   = ifl_w_q;
    ifl_v2_d  = ifl_v2_q;
    if (issue) begin
      pc_d     = nxt_w;
      ifl_w_d  = iss_w;
      ifl_v2_d = (iss_w != LAST_W);
    end else if (redir_valid) begin
      pc_d = iss_w;
    end
  end

  assign ret_vld = ifl_vld_q & ~redir_valid;

  always_comb begin
    ret_pair.pc     = {{(30-ADDR_W){1'b0}}, ifl_w_q, 2'b00};
    ret_pair.instr1 = rom_instr1;
    ret_pair.instr2 = ifl_v2_q ? rom_instr2 : NOP_INSTR;
    ret_pair.valid2 = ifl_v2_q;
  end

  assign skid_load = ret_vld & out_valid & ~out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (fetch_en & ~skid_vld) state_d = ST_RUN;
      ST_RUN: begin
        if (~fetch_en)      state_d = ST_IDLE;
        else if (skid_load) state_d = ST_STALL;
      end
      ST_STALL: if (~skid_vld) state_d = fetch_en ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (redir_valid) state_d = fetch_en ? ST_RUN : ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RST_W;
      ifl_w_q   <= '0;
      ifl_vld_q <= 1'b0;
      ifl_v2_q  <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      pc_q      <= pc_d;
      ifl_w_q   <= ifl_w_d;
      ifl_vld_q <= ifl_vld_d;
      ifl_v2_q  <= ifl_v2_d;
      state_q   <= state_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redir_valid),
    .in_valid_i (ret_vld),
    .in_pair_i  (ret_pair),
    .out_ready_i(out_ready),
    .out_valid_o(out_valid),
    .out_pair_o (out_pair),
    .skid_vld_o (skid_vld)
  );

  assign out_pc     = out_pair.pc;
  assign out_instr1 = out_pair.instr1;
  assign out_instr2 = out_pair.instr2;
  assign out_valid2 = out_pair.valid2;

`ifdef FETCH_PERF_EN
  logic [31:0] pairs_q, stall_q, redir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pairs_q <= '0;
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (out_valid & out_ready)  pairs_q <= pairs_q + 32'd1;
      if (out_valid & ~out_ready) stall_q <= stall_q + 32'd1;
      if (redir_valid)            redir_q <= redir_q + 32'd1;
    end
  end

  assign perf_pairs = pairs_q;
  assign perf_stall = stall_q;
  assign perf_redir = redir_q;
`endif

endmodule
